// File: rtl/spi_peripheral_pkg.sv
// Shared constants and frame layout for the SPI register peripheral.
package spi_peripheral_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 7;

  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } frame_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 peripheral exposing five 8-bit control registers.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  logic sclk_s, copi_s, ncs_s;
  logic sclk_q, ncs_q;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (sclk),
    .q_o   (sclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (copi),
    .q_o   (copi_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (ncs),
    .q_o   (ncs_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      ncs_q  <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      ncs_q  <= ncs_s;
    end
  end

  logic sclk_rise, ncs_fall, ncs_rise;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign ncs_fall  = ~ncs_s & ncs_q;
  assign ncs_rise  = ncs_s & ~ncs_q;

  logic                  armed_q, armed_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bit_accept;
  frame_t                frame;
  logic                  commit;

  // A bit coinciding with ncs rising is dropped because ncs_s is already high.
  assign bit_accept = armed_q & ~ncs_s & sclk_rise;
  assign frame      = frame_t'(shift_q);
  assign commit     = armed_q & ncs_rise & (cnt_q == CNT_FULL) & frame.wr &
                      (frame.addr <= MAX_ADDR);

  always_comb begin
    armed_d = armed_q | ncs_s;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (bit_accept) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
    end
    if (ncs_fall) begin
      cnt_d = '0;
    end else if (bit_accept && cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [7:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
  logic [7:0] out_lo_d, out_hi_d, pwm_lo_d, pwm_hi_d, duty_d;

  always_comb begin
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    pwm_lo_d = pwm_lo_q;
    pwm_hi_d = pwm_hi_q;
    duty_d   = duty_q;
    if (commit) begin
      case (frame.addr)
        ADDR_EN_OUT_7_0:  out_lo_d = frame.data;
        ADDR_EN_OUT_15_8: out_hi_d = frame.data;
        ADDR_EN_PWM_7_0:  pwm_lo_d = frame.data;
        ADDR_EN_PWM_15_8: pwm_hi_d = frame.data;
        ADDR_PWM_DUTY:    duty_d   = frame.data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lo_q <= 8'h00;
      out_hi_q <= 8'h00;
      pwm_lo_q <= 8'h00;
      pwm_hi_q <= 8'h00;
      duty_q   <= 8'h00;
    end else begin
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      pwm_lo_q <= pwm_lo_d;
      pwm_hi_q <= pwm_hi_d;
      duty_q   <= duty_d;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: writes, discards, latency and reset behaviour.
`timescale 1ns/1ps
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  spi_peripheral dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle)
  );

  // Order: out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty
  logic [39:0] regs;
  assign regs = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
                 pwm_duty_cycle};

  task automatic cs_low();
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    cs_low();
    shift_bits(v, n);
    ncs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (regs !== 40'h0) $display("FAIL reset_state: got %h want %h", regs, 40'h0);
    else passed++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_write();
    cs_low();
    shift_bits(32'h80F0, 16);
    ncs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (regs !== 40'h0) $display("FAIL latency_early: got %h want %h", regs, 40'h0);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (regs !== 40'hF0_00_00_00_00)
      $display("FAIL latency_3clk: got %h want %h", regs, 40'hF0_00_00_00_00);
    else passed++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    frame(32'h8480, 16);
    checks++;
    if (regs !== 40'hF0_00_00_00_80)
      $display("FAIL b2b_duty: got %h want %h", regs, 40'hF0_00_00_00_80);
    else passed++;
    frame(32'h8201, 16);
    checks++;
    if (regs !== 40'hF0_00_01_00_80)
      $display("FAIL b2b_pwm_lo: got %h want %h", regs, 40'hF0_00_01_00_80);
    else passed++;
  endtask

  task automatic test_discard();
    frame(32'h05AA, 16);
    checks++;
    if (regs !== 40'hF0_00_01_00_80)
      $display("FAIL read_frame: got %h want %h", regs, 40'hF0_00_01_00_80);
    else passed++;
    frame(32'h85AA, 16);
    checks++;
    if (regs !== 40'hF0_00_01_00_80)
      $display("FAIL addr_over_max: got %h want %h", regs, 40'hF0_00_01_00_80);
    else passed++;
    frame(32'h817F >> 1, 15);
    checks++;
    if (regs !== 40'hF0_00_01_00_80)
      $display("FAIL short_frame: got %h want %h", regs, 40'hF0_00_01_00_80);
    else passed++;
    frame({15'h0, 16'h8155, 1'b1}, 17);
    checks++;
    if (en_reg_out_15_8 !== 8'h00)
      $display("FAIL long_frame_reg: got %h want %h", en_reg_out_15_8, 8'h00);
    else passed++;
    checks++;
    if (regs !== 40'hF0_00_01_00_80)
      $display("FAIL long_frame_all: got %h want %h", regs, 40'hF0_00_01_00_80);
    else passed++;
  endtask

  task automatic test_addr_01();
    frame(32'h8112, 16);
    checks++;
    if (regs !== 40'hF0_12_01_00_80)
      $display("FAIL write_addr01: got %h want %h", regs, 40'hF0_12_01_00_80);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    cs_low();
    shift_bits(32'h83, 8);
    // Assert reset away from any clock edge; outputs must clear at once.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (regs !== 40'h0) $display("FAIL async_reset: got %h want %h", regs, 40'h0);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    shift_bits(32'h3C, 8);
    ncs = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (regs !== 40'h0) $display("FAIL aborted_frame: got %h want %h", regs, 40'h0);
    else passed++;
    frame(32'h833C, 16);
    checks++;
    if (regs !== 40'h00_00_00_3C_00)
      $display("FAIL post_reset_write: got %h want %h", regs, 40'h00_00_00_3C_00);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_discard();
    test_addr_01();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
